// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master front-end.
package apb_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // Index of requester 'off' places after 'base' on a ring of n requesters.
  function automatic int rr_wrap(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot winner searched from the pointer; the pointer
// moves past the winner whenever the grant strobe is taken.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt,
  output logic         any
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan the ring starting at the pointer; the first active request wins.
  always_comb begin
    gnt     = '0;
    win_s   = ptr_r;
    idx_s   = ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'(rr_wrap(int'(ptr_r), k, N));
      if (!found_s && req[idx_s]) begin
        found_s    = 1'b1;
        gnt[idx_s] = 1'b1;
        win_s      = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = found_s;

  // Pointer register: next search starts just after the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= PW'(rr_wrap(int'(win_s), 1, N));
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 master shared by NUM_REQ requesters: round-robin grant, then the
// IDLE -> SETUP -> ACCESS sequence with an ACCESS-phase stall timeout.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pslverr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e          state_r, state_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [NUM_REQ-1:0]  arb_gnt_s;
  logic                arb_any_s;
  logic                grant_s;
  logic [ADDR_W-1:0]   sel_addr_s, paddr_s;
  logic [DATA_W-1:0]   sel_wdata_s, pwdata_s;
  logic                sel_write_s, pwrite_s;
  logic [NUM_REQ-1:0]  rsp_valid_s;
  logic [DATA_W-1:0]   rsp_rdata_s;
  logic                rsp_err_s;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (pclk),
    .rst_n   (presetn),
    .req     (req_valid),
    .advance (grant_s),
    .gnt     (arb_gnt_s),
    .any     (arb_any_s)
  );

  // One-hot mux of the winning requester's fields.
  always_comb begin
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    sel_write_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s  = sel_addr_s  | (req_addr[i*ADDR_W +: ADDR_W]  & {ADDR_W{arb_gnt_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{arb_gnt_s[i]}});
      sel_write_s = sel_write_s | (req_write[i] & arb_gnt_s[i]);
    end
  end

  // Next state, captured transfer fields and completion response.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    gnt_s       = gnt_r;
    cnt_s       = cnt_r;
    paddr_s     = paddr;
    pwrite_s    = pwrite;
    pwdata_s    = pwdata;
    rsp_valid_s = '0;
    rsp_rdata_s = '0;
    rsp_err_s   = 1'b0;
    case (state_r)
      APB_IDLE: begin
        // Holding off while a response is out lets its requester drop req_valid.
        if ((rsp_valid == '0) && arb_any_s) begin
          grant_s  = 1'b1;
          state_s  = APB_SETUP;
          gnt_s    = arb_gnt_s;
          paddr_s  = sel_addr_s;
          pwrite_s = sel_write_s;
          pwdata_s = sel_wdata_s;
        end else begin
          state_s = APB_IDLE;
        end
      end
      APB_SETUP: begin
        state_s = APB_ACCESS;
        cnt_s   = '0;
      end
      APB_ACCESS: begin
        if (pready) begin
          state_s     = APB_IDLE;
          cnt_s       = '0;
          rsp_valid_s = gnt_r;
          rsp_rdata_s = pwrite ? '0 : prdata;
          rsp_err_s   = pslverr;
        end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
          state_s     = APB_IDLE;
          cnt_s       = '0;
          rsp_valid_s = gnt_r;
          rsp_err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = APB_IDLE;
      end
    endcase
  end

  // State and all outputs are registered from the next-state values.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r   <= APB_IDLE;
      gnt_r     <= '0;
      cnt_r     <= '0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      cnt_r     <= cnt_s;
      paddr     <= paddr_s;
      pwrite    <= pwrite_s;
      pwdata    <= pwdata_s;
      psel      <= (state_s != APB_IDLE);
      penable   <= (state_s == APB_ACCESS);
      busy      <= (state_s != APB_IDLE);
      rsp_valid <= rsp_valid_s;
      rsp_rdata <= rsp_rdata_s;
      rsp_err   <= rsp_err_s;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with hand-computed expectations.
module tb_apb_master_arbiter;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [1:0]  req_valid, req_write;
  logic [31:0] a0, a1, d0, d1;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err, busy;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int checks   = 0;
  int failures = 0;
  int exp_seq [4] = '{1, 0, 1, 0};

  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};

  apb_master_arbiter dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    presetn = 1'b0; req_valid = 2'b00; req_write = 2'b00;
    a0 = 32'h0; a1 = 32'h0; d0 = 32'h0; d1 = 32'h0;
    pready = 1'b1; prdata = 32'h0; pslverr = 1'b0;
    tick(); tick();
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_paddr", paddr, 32'h0);
    presetn = 1'b1;
    tick();
    chk("idle_psel", psel, 1'b0);

    // 1: single zero-wait write from requester 0
    req_valid = 2'b01; req_write = 2'b01; a0 = 32'h10; d0 = 32'h0000_A5A5;
    tick();
    chk("t1_setup_psel", psel, 1'b1);
    chk("t1_setup_penable", penable, 1'b0);
    chk("t1_paddr", paddr, 32'h10);
    chk("t1_pwrite", pwrite, 1'b1);
    chk("t1_pwdata", pwdata, 32'h0000_A5A5);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_access_penable", penable, 1'b1);
    chk("t1_access_rsp", rsp_valid, 2'b00);
    tick();
    chk("t1_rsp_valid", rsp_valid, 2'b01);
    chk("t1_rsp_err", rsp_err, 1'b0);
    chk("t1_rsp_rdata", rsp_rdata, 32'h0);
    chk("t1_psel_drop", psel, 1'b0);
    req_valid = 2'b00;
    tick();
    chk("t1_rsp_pulse", rsp_valid, 2'b00);

    // 2: read with three wait states
    req_valid = 2'b01; req_write = 2'b00; a0 = 32'h24; pready = 1'b0; prdata = 32'hDEAD_BEEF;
    tick();
    chk("t2_setup", {psel, penable}, 2'b10);
    tick();
    chk("t2_access1", {psel, penable}, 2'b11);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("t2_wait_penable", penable, 1'b1);
      chk("t2_wait_paddr", paddr, 32'h24);
      chk("t2_wait_rsp", rsp_valid, 2'b00);
    end
    pready = 1'b1;
    tick();
    chk("t2_rsp_valid", rsp_valid, 2'b01);
    chk("t2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("t2_rsp_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    tick();

    // 3: both requesters held; pointer sits at 1 after two grants to 0
    req_valid = 2'b11; req_write = 2'b11;
    a0 = 32'h100; a1 = 32'h200; d0 = 32'h1111; d1 = 32'h2222;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("t3_grant_psel", psel, 1'b1);
      chk("t3_grant_paddr", paddr, (exp_seq[t] == 0) ? 32'h100 : 32'h200);
      chk("t3_grant_pwdata", pwdata, (exp_seq[t] == 0) ? 32'h1111 : 32'h2222);
      tick();
      chk("t3_access", penable, 1'b1);
      tick();
      chk("t3_rsp_valid", rsp_valid, (exp_seq[t] == 0) ? 2'b01 : 2'b10);
      if (t == 3) req_valid = 2'b00;
      tick();
      chk("t3_gap_psel", psel, 1'b0);
    end

    // 5: slave error on a write, then a clean read from the lone requester 1
    req_valid = 2'b10; req_write = 2'b10; a1 = 32'h300; d1 = 32'h3333; pslverr = 1'b1;
    tick(); tick(); tick();
    chk("t5_err_rsp", rsp_valid, 2'b10);
    chk("t5_err_flag", rsp_err, 1'b1);
    req_valid = 2'b00; pslverr = 1'b0;
    tick();
    req_valid = 2'b10; req_write = 2'b00; a1 = 32'h304; prdata = 32'h1234_5678;
    tick();
    chk("t5_lone_paddr", paddr, 32'h304);
    tick(); tick();
    chk("t5_ok_rsp", rsp_valid, 2'b10);
    chk("t5_ok_err", rsp_err, 1'b0);
    chk("t5_ok_rdata", rsp_rdata, 32'h1234_5678);
    req_valid = 2'b00;
    tick();

    // 4: pready stuck low -> forced completion after 16 ACCESS cycles
    req_valid = 2'b01; req_write = 2'b00; a0 = 32'h40; pready = 1'b0; prdata = 32'hFFFF_FFFF;
    tick(); tick();
    chk("t4_access1", penable, 1'b1);
    for (int c = 0; c < 15; c++) begin
      tick();
      chk("t4_stall_penable", penable, 1'b1);
      chk("t4_stall_rsp", rsp_valid, 2'b00);
    end
    tick();
    chk("t4_to_rsp", rsp_valid, 2'b01);
    chk("t4_to_err", rsp_err, 1'b1);
    chk("t4_to_rdata", rsp_rdata, 32'h0);
    chk("t4_to_idle", {busy, psel, penable}, 3'b000);
    req_valid = 2'b00;
    tick();

    // 6: reset during ACCESS aborts; the held request then completes anew
    req_valid = 2'b01; req_write = 2'b01; a0 = 32'h50; d0 = 32'h5555;
    tick(); tick();
    chk("t6_in_access", penable, 1'b1);
    presetn = 1'b0;
    #1;
    chk("t6_rst_psel", psel, 1'b0);
    chk("t6_rst_penable", penable, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    pready = 1'b1;
    tick(); tick();
    chk("t6_rst_rsp", rsp_valid, 2'b00);
    presetn = 1'b1;
    tick();
    chk("t6_regrant_paddr", paddr, 32'h50);
    chk("t6_regrant_psel", psel, 1'b1);
    tick(); tick();
    chk("t6_rsp_valid", rsp_valid, 2'b01);
    chk("t6_rsp_err", rsp_err, 1'b0);
    req_valid = 2'b00;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
